// File: rtl/request_arbiter_pkg.sv
// Shared types and constants for the 4-requester arbiter.
package arb_pkg;
  localparam int N_REQ  = 4;
  localparam int ID_W   = 2;
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/request_arbiter_if.sv
// Request/grant bundle between requesting units (master) and the arbiter (slave).
interface request_arbiter_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_vld;
  logic             preempt;

  modport master (output req, input gnt, gnt_id, gnt_vld, preempt);
  modport slave  (input req, output gnt, gnt_id, gnt_vld, preempt);
endinterface

// File: rtl/request_arbiter_sel.sv
// Combinational priority pick: scan req downward from ptr with wrap, first set bit wins.
module rotating_priority_select
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  win_id,
  output logic             win_vld
);
  logic [ID_W-1:0] idx;

  always_comb begin
    win_vld = 1'b0;
    win_id  = ptr;
    idx     = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr - ID_W'(i);
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end
endmodule

// File: rtl/request_arbiter.sv
// Arbiter FSM: grant hold, hold-limit preemption, one turnaround cycle between owners.
module request_arbiter
  import arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 0,
  parameter int MAX_HOLD    = 8
) (
  input  logic              clk,
  input  logic              rst,
  request_arbiter_if.slave  bus
);
  localparam logic [HOLD_W-1:0] HOLD_LIM = MAX_HOLD[HOLD_W-1:0];
  localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

  arb_state_t      state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win_id;
  logic            win_vld;

  rotating_priority_select u_sel (
    .req     (bus.req),
    .ptr     (ptr),
    .win_id  (win_id),
    .win_vld (win_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bus.gnt     <= '0;
      bus.gnt_id  <= '0;
      bus.gnt_vld <= 1'b0;
      bus.preempt <= 1'b0;
      hold_cnt    <= '0;
      ptr         <= ID_W'(N_REQ - 1);
    end else begin
      bus.preempt <= 1'b0;
      case (state)
        IDLE, TURN: begin
          if (win_vld) begin
            state       <= GRANT;
            bus.gnt     <= N_REQ'(1) << win_id;
            bus.gnt_id  <= win_id;
            bus.gnt_vld <= 1'b1;
            hold_cnt    <= HOLD_W'(1);
            if (ROUND_ROBIN != 0) ptr <= win_id - ID_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          // Release has precedence; new requesters only compete in TURN.
          if (!bus.req[bus.gnt_id]) begin
            state       <= TURN;
            bus.gnt     <= '0;
            bus.gnt_vld <= 1'b0;
            hold_cnt    <= '0;
          end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LIM) begin
            state       <= TURN;
            bus.gnt     <= '0;
            bus.gnt_vld <= 1'b0;
            bus.preempt <= 1'b1;
            hold_cnt    <= '0;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          bus.gnt     <= '0;
          bus.gnt_vld <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_request_arbiter.sv
// Scoreboard bench: three arbiter configurations, directed vectors, per-edge monitor.
module tb_request_arbiter;
  logic clk;
  logic rst;

  request_arbiter_if ia ();  // fixed, MAX_HOLD=4
  request_arbiter_if ib ();  // rotating, MAX_HOLD=2
  request_arbiter_if ic ();  // fixed, unlimited hold

  request_arbiter #(.ROUND_ROBIN(0), .MAX_HOLD(4)) u_a (.clk(clk), .rst(rst), .bus(ia));
  request_arbiter #(.ROUND_ROBIN(1), .MAX_HOLD(2)) u_b (.clk(clk), .rst(rst), .bus(ib));
  request_arbiter #(.ROUND_ROBIN(0), .MAX_HOLD(0)) u_c (.clk(clk), .rst(rst), .bus(ic));

  typedef struct {
    int         dut;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       pre;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample(int d, output logic [3:0] g, output logic [1:0] id,
                        output logic v, output logic p);
    case (d)
      0:       begin g = ia.gnt; id = ia.gnt_id; v = ia.gnt_vld; p = ia.preempt; end
      1:       begin g = ib.gnt; id = ib.gnt_id; v = ib.gnt_vld; p = ib.preempt; end
      default: begin g = ic.gnt; id = ic.gnt_id; v = ic.gnt_vld; p = ic.preempt; end
    endcase
  endtask

  task automatic check_entry(exp_t e);
    logic [3:0] g;
    logic [1:0] id;
    logic       v, p;
    sample(e.dut, g, id, v, p);
    cmp({e.tag, ".gnt"}, 32'(g), 32'(e.gnt));
    cmp({e.tag, ".vld"}, 32'(v), 32'(|e.gnt));
    cmp({e.tag, ".pre"}, 32'(p), 32'(e.pre));
    if (e.gnt != 4'b0000) cmp({e.tag, ".id"}, 32'(id), 32'(e.id));
  endtask

  // Monitor: one edge after each stimulus, drain expectations and check one-hot.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cmp("onehot", 32'({$onehot0(ia.gnt), $onehot0(ib.gnt), $onehot0(ic.gnt)}), 32'h7);
      while (q.size() > 0) check_entry(q.pop_front());
    end
  end

  task automatic drive(int d, logic [3:0] r, logic [3:0] g, logic [1:0] id, logic pre,
                       string tag);
    exp_t e;
    case (d)
      0:       ia.req = r;
      1:       ib.req = r;
      default: ic.req = r;
    endcase
    e.dut = d; e.gnt = g; e.id = id; e.pre = pre; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic step(int d, logic [3:0] r, logic [3:0] g, logic [1:0] id, logic pre,
                      string tag);
    @(negedge clk);
    drive(d, r, g, id, pre, tag);
  endtask

  task automatic check_zero(int d, string tag);
    logic [3:0] g;
    logic [1:0] id;
    logic       v, p;
    sample(d, g, id, v, p);
    cmp({tag, ".gnt"}, 32'(g), 32'h0);
    cmp({tag, ".id"},  32'(id), 32'h0);
    cmp({tag, ".vld"}, 32'(v), 32'h0);
    cmp({tag, ".pre"}, 32'(p), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ia.req = '0; ib.req = '0; ic.req = '0;
    #2;
    for (int d = 0; d < 3; d++) check_zero(d, "reset");
    @(negedge clk);
    rst = 1'b0;

    // Fixed priority: 2 over 1, then 1 after turnaround.
    step(0, 4'b0110, 4'b0100, 2, 0, "fix_win2");
    step(0, 4'b0110, 4'b0100, 2, 0, "fix_hold2");
    step(0, 4'b0010, 4'b0000, 0, 0, "fix_rel2");
    step(0, 4'b0010, 4'b0010, 1, 0, "fix_win1");
    step(0, 4'b0000, 4'b0000, 0, 0, "fix_rel1");
    step(0, 4'b0000, 4'b0000, 0, 0, "fix_idle");

    // Hold limit 4 on requester 3, re-won after turnaround.
    for (int i = 0; i < 4; i++) step(0, 4'b1000, 4'b1000, 3, 0, "lim_hold");
    step(0, 4'b1000, 4'b0000, 0, 1, "lim_preempt");
    step(0, 4'b1000, 4'b1000, 3, 0, "lim_rewin");
    step(0, 4'b0000, 4'b0000, 0, 0, "lim_rel");
    step(0, 4'b0000, 4'b0000, 0, 0, "lim_idle");

    // Release of owner 1 coincides with req[3] arriving.
    step(0, 4'b0010, 4'b0010, 1, 0, "sim_win1");
    step(0, 4'b0010, 4'b0010, 1, 0, "sim_hold1");
    step(0, 4'b1000, 4'b0000, 0, 0, "sim_turn");
    step(0, 4'b1000, 4'b1000, 3, 0, "sim_win3");
    step(0, 4'b0000, 4'b0000, 0, 0, "sim_rel");

    // Rotating, MAX_HOLD=2, all requesting: owners 3,2,1,0,3.
    for (int k = 0; k < 4; k++) begin
      logic [1:0] w;
      w = 2'(3 - k);
      step(1, 4'b1111, 4'b0001 << w, w, 0, "rr_g1");
      step(1, 4'b1111, 4'b0001 << w, w, 0, "rr_g2");
      step(1, 4'b1111, 4'b0000, 0, 1, "rr_turn");
    end
    step(1, 4'b1111, 4'b1000, 3, 0, "rr_wrap3");
    step(1, 4'b0000, 4'b0000, 0, 0, "rr_rel");
    step(1, 4'b0000, 4'b0000, 0, 0, "rr_idle");

    // Unlimited hold: 300 cycles, counter must saturate without release.
    for (int i = 0; i < 300; i++) step(2, 4'b0001, 4'b0001, 0, 0, "inf_hold");
    step(2, 4'b0000, 4'b0000, 0, 0, "inf_rel");

    // Asynchronous reset in the middle of a grant.
    step(0, 4'b0100, 4'b0100, 2, 0, "rst_pre");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero(0, "rst_async");
    @(negedge clk);
    rst = 1'b0;
    drive(0, 4'b0100, 4'b0100, 2, 0, "rst_regrant");
    step(0, 4'b0000, 4'b0000, 0, 0, "rst_rel");
    step(0, 4'b0000, 4'b0000, 0, 0, "rst_idle");

    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
